// File: rtl/hello_checker.sv
// Sequence checker for the hello counter's (q, flag) output: locks onto the
// count, then flags out-of-sequence values and keeps error/wrap statistics.
module hello_checker #(
    parameter int WIDTH    = 5,
    parameter int TERMINAL = 31,
    parameter int LOCK_RUN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             flag_in,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [7:0]       wrap_count,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED, FAULT} state_t;

    localparam logic [WIDTH-1:0] TERM       = WIDTH'(TERMINAL);
    localparam logic [3:0]       RUN_TARGET = 4'(LOCK_RUN);

    state_t           state, state_nxt;
    logic [3:0]       run, run_nxt;
    logic [WIDTH-1:0] expected_nxt;
    logic [7:0]       err_count_nxt, wrap_count_nxt;

    logic             is_term, flag_ok, correct;
    logic [WIDTH-1:0] q_next;

    assign is_term = (q_in == TERM);
    assign flag_ok = (flag_in == is_term);
    assign correct = (q_in == expected) && flag_ok;
    assign q_next  = is_term ? '0 : q_in + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            run        <= '0;
            expected   <= '0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            run        <= run_nxt;
            expected   <= expected_nxt;
            err_count  <= err_count_nxt;
            wrap_count <= wrap_count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        run_nxt        = run;
        expected_nxt   = expected;
        err_count_nxt  = err_count;
        wrap_count_nxt = wrap_count;
        case (state)
            HUNT: begin
                if (q_in == '0 && flag_ok) begin
                    state_nxt    = ACQUIRE;
                    expected_nxt = WIDTH'(1);
                    run_nxt      = '0;
                end
            end
            ACQUIRE: begin
                if (correct) begin
                    run_nxt      = run + 4'd1;
                    expected_nxt = q_next;
                    if (run_nxt == RUN_TARGET)
                        state_nxt = LOCKED;
                end else begin
                    state_nxt    = HUNT;
                    run_nxt      = '0;
                    expected_nxt = '0;
                end
            end
            LOCKED: begin
                if (correct) begin
                    expected_nxt = q_next;
                    if (is_term)
                        wrap_count_nxt = wrap_count + 8'd1;
                end else begin
                    state_nxt = FAULT;
                    if (err_count != 8'hFF)
                        err_count_nxt = err_count + 8'd1;
                end
            end
            FAULT: begin
                // Inputs are ignored here, so a 0 in this cycle cannot start acquisition.
                state_nxt    = HUNT;
                run_nxt      = '0;
                expected_nxt = '0;
            end
            default: begin
                state_nxt    = HUNT;
                run_nxt      = '0;
                expected_nxt = '0;
            end
        endcase
    end

    // The FAULT state lasts one cycle, so decoding it yields the error pulse.
    always_comb begin
        locked = (state == LOCKED);
        err    = (state == FAULT);
    end

endmodule

// File: tb/tb_hello_checker.sv
// Directed bench for hello_checker: a vector table followed by hand-written
// sequences for wrap, flag faults, saturation and async reset.
module tb_hello_checker;

    logic       clk;
    logic       reset;
    logic [4:0] q_in;
    logic       flag_in;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [4:0] expected;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] q;
        logic       f;
        logic       lk;
        logic       er;
        logic [7:0] ec;
        logic [7:0] wc;
        logic [4:0] ex;
    } vec_t;

    vec_t vecs[$];

    hello_checker #(.WIDTH(5), .TERMINAL(31), .LOCK_RUN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .flag_in    (flag_in),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .expected   (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [4:0] q, input logic f);
        q_in    = q;
        flag_in = f;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic lk, input logic er,
                               input logic [7:0] ec, input logic [7:0] wc,
                               input logic [4:0] ex);
        checks++;
        if ({locked, err, err_count, wrap_count, expected} !== {lk, er, ec, wc, ex}) begin
            errors++;
            $display("[TB] FAIL %s: got locked=%0b err=%0b err_count=%0d wrap_count=%0d expected=%0d, want locked=%0b err=%0b err_count=%0d wrap_count=%0d expected=%0d",
                     name, locked, err, err_count, wrap_count, expected, lk, er, ec, wc, ex);
        end
    endtask

    // Acquire from HUNT with 0..4; ends locked with 5 predicted.
    task automatic lockUp(input logic [7:0] ec, input logic [7:0] wc);
        for (int v = 0; v <= 4; v++)
            applyStimulus(5'(v), 1'b0);
        checkOutput("relock", 1'b1, 1'b0, ec, wc, 5'd5);
    endtask

    initial begin
        logic [7:0] ecm;
        logic [7:0] wcm;

        vecs.push_back('{5'd0,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 5'd1});
        vecs.push_back('{5'd1,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 5'd2});
        vecs.push_back('{5'd2,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 5'd3});
        vecs.push_back('{5'd3,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 5'd4});
        vecs.push_back('{5'd4,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 5'd5});
        vecs.push_back('{5'd5,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 5'd6});
        vecs.push_back('{5'd6,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 5'd7});
        vecs.push_back('{5'd7,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 5'd8});
        vecs.push_back('{5'd9,  1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 5'd8});
        vecs.push_back('{5'd0,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd0});
        vecs.push_back('{5'd0,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd1});
        vecs.push_back('{5'd1,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd2});
        vecs.push_back('{5'd2,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd3});
        vecs.push_back('{5'd5,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd0});
        vecs.push_back('{5'd0,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd1});
        vecs.push_back('{5'd1,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd2});
        vecs.push_back('{5'd2,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd3});
        vecs.push_back('{5'd3,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 5'd4});
        vecs.push_back('{5'd4,  1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd5});
        vecs.push_back('{5'd5,  1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd6});
        vecs.push_back('{5'd6,  1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd7});
        vecs.push_back('{5'd7,  1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd8});
        vecs.push_back('{5'd8,  1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd9});
        vecs.push_back('{5'd9,  1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd10});
        vecs.push_back('{5'd10, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd11});
        vecs.push_back('{5'd11, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 5'd12});
        vecs.push_back('{5'd12, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0, 5'd12});
        vecs.push_back('{5'd3,  1'b0, 1'b0, 1'b0, 8'd2, 8'd0, 5'd0});
        vecs.push_back('{5'd0,  1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 5'd0});
        vecs.push_back('{5'd31, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 5'd0});

        reset   = 1'b0;
        q_in    = 5'd0;
        flag_in = 1'b0;
        #10;
        checkOutput("reset_state", 1'b0, 1'b0, 8'd0, 8'd0, 5'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].q, vecs[i].f);
            checkOutput($sformatf("vec%0d", i), vecs[i].lk, vecs[i].er,
                        vecs[i].ec, vecs[i].wc, vecs[i].ex);
        end

        // Clean lock through a full count and the first wrap.
        for (int v = 0; v <= 3; v++)
            applyStimulus(5'(v), 1'b0);
        checkOutput("not_locked_at_3", 1'b0, 1'b0, 8'd2, 8'd0, 5'd4);
        applyStimulus(5'd4, 1'b0);
        checkOutput("locked_at_4", 1'b1, 1'b0, 8'd2, 8'd0, 5'd5);
        for (int v = 5; v <= 30; v++)
            applyStimulus(5'(v), 1'b0);
        applyStimulus(5'd31, 1'b1);
        checkOutput("first_wrap", 1'b1, 1'b0, 8'd2, 8'd1, 5'd0);

        // Terminal value without its flag is an error only.
        for (int v = 0; v <= 30; v++)
            applyStimulus(5'(v), 1'b0);
        checkOutput("expect_terminal", 1'b1, 1'b0, 8'd2, 8'd1, 5'd31);
        applyStimulus(5'd31, 1'b0);
        checkOutput("term_flag_fault", 1'b0, 1'b1, 8'd3, 8'd1, 5'd31);
        applyStimulus(5'd0, 1'b0);
        checkOutput("fault_ignores_zero", 1'b0, 1'b0, 8'd3, 8'd1, 5'd0);
        applyStimulus(5'd1, 1'b0);
        checkOutput("hunt_ignores_one", 1'b0, 1'b0, 8'd3, 8'd1, 5'd0);
        applyStimulus(5'd0, 1'b0);
        checkOutput("reacquire", 1'b0, 1'b0, 8'd3, 8'd1, 5'd1);
        for (int v = 1; v <= 4; v++)
            applyStimulus(5'(v), 1'b0);
        checkOutput("relocked", 1'b1, 1'b0, 8'd3, 8'd1, 5'd5);

        // Saturating error counter over 260 locked faults.
        ecm = 8'd3;
        for (int i = 0; i < 260; i++) begin
            if (i > 0)
                lockUp(ecm, 8'd1);
            applyStimulus(5'd9, 1'b0);
            ecm = (ecm == 8'd255) ? 8'd255 : ecm + 8'd1;
            checkOutput("sat_fault", 1'b0, 1'b1, ecm, 8'd1, 5'd5);
            applyStimulus(5'd0, 1'b0);
            checkOutput("sat_clear", 1'b0, 1'b0, ecm, 8'd1, 5'd0);
        end
        checkOutput("sat_final", 1'b0, 1'b0, 8'd255, 8'd1, 5'd0);

        // Async reset between edges while locked.
        lockUp(8'd255, 8'd1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, 8'd0, 8'd0, 5'd0);
        #2;
        reset = 1'b1;
        for (int v = 0; v <= 3; v++)
            applyStimulus(5'(v), 1'b0);
        checkOutput("post_reset_3", 1'b0, 1'b0, 8'd0, 8'd0, 5'd4);
        applyStimulus(5'd4, 1'b0);
        checkOutput("post_reset_4", 1'b1, 1'b0, 8'd0, 8'd0, 5'd5);

        // 257 clean wraps from zero.
        wcm = 8'd0;
        for (int v = 5; v <= 30; v++)
            applyStimulus(5'(v), 1'b0);
        for (int w = 0; w < 257; w++) begin
            if (w > 0)
                for (int v = 0; v <= 30; v++)
                    applyStimulus(5'(v), 1'b0);
            applyStimulus(5'd31, 1'b1);
            wcm = wcm + 8'd1;
            checkOutput("wrap", 1'b1, 1'b0, 8'd0, wcm, 5'd0);
        end
        checkOutput("wrap_final", 1'b1, 1'b0, 8'd0, 8'd1, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
